conv_layer_scheduler: RTL

//  Sequencer for the 32-tap multiply-adder datapath of the 1-D conv layer. On start, for each
//  of KERNEL_NUM kernels it loads 32 weights + bias from weight memory, then for every output

---
 rtl/conv_layer_scheduler_if.sv | 41 ++++
 rtl/conv_layer_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/conv_layer_scheduler_if.sv
// Bus bundle between the conv layer scheduler and its weight memory, data buffer,
// MAC datapath and result consumer.
interface conv_layer_scheduler_if;
    logic       w_rd_en;
    logic [8:0] w_addr;
    logic [7:0] w_rdata;
    logic       d_rd_en;
    logic [8:0] d_addr;
    logic [7:0] d_rdata;
    logic       mac_w_valid;
    logic [7:0] mac_weight;
    logic [7:0] mac_bias;
    logic       mac_d_valid;
    logic [7:0] mac_data;
    logic [4:0] mac_idx;
    logic [7:0] mac_result;
    logic       mac_rvalid;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_kernel;
    logic [5:0] out_pos;
    logic       out_ready;

    modport master (
        output w_rd_en, w_addr, input w_rdata,
        output d_rd_en, d_addr, input d_rdata,
        output mac_w_valid, mac_weight, mac_bias, mac_d_valid, mac_data, mac_idx,
        input  mac_result, mac_rvalid,
        output out_valid, out_data, out_kernel, out_pos,
        input  out_ready
    );

    modport slave (
        input  w_rd_en, w_addr, output w_rdata,
        input  d_rd_en, d_addr, output d_rdata,
        input  mac_w_valid, mac_weight, mac_bias, mac_d_valid, mac_data, mac_idx,
        output mac_result, mac_rvalid,
        input  out_valid, out_data, out_kernel, out_pos,
        output out_ready
    );
endinterface

// File: rtl/conv_layer_scheduler.sv
// Sequencer for the 1-D conv layer MAC: loads weights/bias per kernel, streams one
// window per output position into the MAC and hands each result out on ready/valid.
module conv_layer_scheduler #(
    parameter int KERNEL_SIZE  = 32,
    parameter int DATA_LENGTH  = 512,
    parameter int STRIDE       = 8,
    parameter int KERNEL_NUM   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    conv_layer_scheduler_if.master bus
);
    localparam int NPOS = (DATA_LENGTH - KERNEL_SIZE) / STRIDE + 1;
    localparam int IW   = $clog2(KERNEL_SIZE + 1);
    localparam int MIW  = $clog2(KERNEL_SIZE);
    localparam int KW   = $clog2(KERNEL_NUM);
    localparam int PW   = $clog2(NPOS);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, LOAD_D, WAIT_MAC, OUTPUT, FINISH} state_t;
    state_t state, state_n;

    logic [IW-1:0]           i;
    logic [KW-1:0]           k;
    logic [PW-1:0]           p;
    logic                    w_pend, b_pend, d_pend;
    logic [MIW-1:0]          idx_pend, idx_q;
    logic                    w_valid_q, d_valid_q;
    logic [WEIGHT_WIDTH-1:0] weight_q;
    logic [BIAS_WIDTH-1:0]   bias_q;
    logic [DATA_WIDTH-1:0]   data_q, result_q;
    logic                    last_tap, drained, w_rd, d_rd;

    assign last_tap = (i == IW'(KERNEL_SIZE - 1));
    // The result only counts once the final sample has left the forwarding pipeline.
    assign drained  = !d_pend && !d_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        w_rd    = 1'b0;
        d_rd    = 1'b0;
        case (state)
            IDLE:     if (start) state_n = LOAD_W;
            LOAD_W: begin
                busy = 1'b1;
                w_rd = 1'b1;
                if (last_tap) state_n = LOAD_B;
            end
            LOAD_B: begin
                busy    = 1'b1;
                w_rd    = 1'b1;
                state_n = LOAD_D;
            end
            LOAD_D: begin
                busy = 1'b1;
                d_rd = 1'b1;
                if (last_tap) state_n = WAIT_MAC;
            end
            WAIT_MAC: begin
                busy = 1'b1;
                if (bus.mac_rvalid && drained) state_n = OUTPUT;
            end
            OUTPUT: begin
                busy = 1'b1;
                if (bus.out_ready) begin
                    if (p != PW'(NPOS - 1))            state_n = LOAD_D;
                    else if (k != KW'(KERNEL_NUM - 1)) state_n = LOAD_W;
                    else                               state_n = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i         <= '0;
            k         <= '0;
            p         <= '0;
            w_pend    <= 1'b0;
            b_pend    <= 1'b0;
            d_pend    <= 1'b0;
            idx_pend  <= '0;
            idx_q     <= '0;
            w_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            weight_q  <= '0;
            bias_q    <= '0;
            data_q    <= '0;
            result_q  <= '0;
        end else begin
            w_pend    <= (state == LOAD_W);
            b_pend    <= (state == LOAD_B);
            d_pend    <= (state == LOAD_D);
            w_valid_q <= w_pend;
            d_valid_q <= d_pend;
            if (state == LOAD_W || state == LOAD_D) idx_pend <= i[MIW-1:0];
            if (w_pend || d_pend) idx_q <= idx_pend;
            if (w_pend) weight_q <= bus.w_rdata;
            if (b_pend) bias_q   <= bus.w_rdata;
            if (d_pend) data_q   <= bus.d_rdata;
            if (state == WAIT_MAC && bus.mac_rvalid && drained) result_q <= bus.mac_result;

            case (state)
                IDLE: if (start) begin
                    i <= '0;
                    k <= '0;
                    p <= '0;
                end
                LOAD_W: i <= last_tap ? IW'(KERNEL_SIZE) : i + 1'b1;
                LOAD_B: i <= '0;
                LOAD_D: i <= last_tap ? '0 : i + 1'b1;
                OUTPUT: if (bus.out_ready) begin
                    i <= '0;
                    if (p != PW'(NPOS - 1)) p <= p + 1'b1;
                    else begin
                        p <= '0;
                        if (k != KW'(KERNEL_NUM - 1)) k <= k + 1'b1;
                    end
                end
                FINISH: begin
                    k <= '0;
                    p <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.w_rd_en     = w_rd;
    assign bus.w_addr      = w_rd ? 9'(int'(k) * (KERNEL_SIZE + 1) + int'(i)) : '0;
    assign bus.d_rd_en     = d_rd;
    assign bus.d_addr      = d_rd ? 9'(int'(p) * STRIDE + int'(i)) : '0;
    assign bus.mac_w_valid = w_valid_q;
    assign bus.mac_weight  = weight_q;
    assign bus.mac_bias    = bias_q;
    assign bus.mac_d_valid = d_valid_q;
    assign bus.mac_data    = data_q;
    assign bus.mac_idx     = idx_q;
    assign bus.out_valid   = (state == OUTPUT);
    assign bus.out_data    = result_q;
    assign bus.out_kernel  = k;
    assign bus.out_pos     = p;
endmodule
